// File: rtl/vga_pkg.sv
// Shared VGA-pipeline types and helpers: default rectangle entry layout and
// a priority picker for per-rectangle hit vectors.
package vga_pkg;

   localparam int DEF_COORD_W = 10;
   localparam int MAX_RECT    = 16;

   typedef struct packed {
      logic                   en;
      logic                   cut;
      logic [DEF_COORD_W-1:0] x0;
      logic [DEF_COORD_W-1:0] x1;
      logic [DEF_COORD_W-1:0] y0;
      logic [DEF_COORD_W-1:0] y1;
   } rect_t;

   function automatic logic [3:0] lowest_set_idx(input logic [MAX_RECT-1:0] vec);
      logic [3:0] idx;
      logic       found;
      idx   = '0;
      found = 1'b0;
      for (int unsigned i = 0; i < MAX_RECT; i++) begin
         if (vec[i] && !found) begin
            idx   = 4'(i);
            found = 1'b1;
         end
      end
      return idx;
   endfunction

endpackage

// File: rtl/rect_region_engine_if.sv
// Rectangle configuration write channel (valid/ready) for rect_region_engine.
interface rect_region_engine_if #(
   parameter int ID_W    = 2,
   parameter int COORD_W = 10
);
   logic               cfg_valid;
   logic               cfg_ready;
   logic [ID_W-1:0]    cfg_idx;
   logic [COORD_W-1:0] cfg_x0;
   logic [COORD_W-1:0] cfg_x1;
   logic [COORD_W-1:0] cfg_y0;
   logic [COORD_W-1:0] cfg_y1;
   logic               cfg_en;
   logic               cfg_cut;

   modport master (
      output cfg_valid, cfg_idx, cfg_x0, cfg_x1, cfg_y0, cfg_y1, cfg_en, cfg_cut,
      input  cfg_ready
   );

   modport slave (
      input  cfg_valid, cfg_idx, cfg_x0, cfg_x1, cfg_y0, cfg_y1, cfg_en, cfg_cut,
      output cfg_ready
   );
endinterface

// File: rtl/rect_hit_cell.sv
// Combinational hit test of one pixel against one rectangle with optional
// corner cut-outs; all sums are one bit wider than the coordinates.
module rect_hit_cell #(
   parameter int COORD_W = 10,
   parameter int CORN    = 10
) (
   input  logic               en,
   input  logic               cut,
   input  logic [COORD_W-1:0] x0,
   input  logic [COORD_W-1:0] x1,
   input  logic [COORD_W-1:0] y0,
   input  logic [COORD_W-1:0] y1,
   input  logic [COORD_W-1:0] q_x,
   input  logic [COORD_W-1:0] q_y,
   output logic               match
);

   localparam logic [COORD_W:0] CORN_E   = (COORD_W+1)'(CORN);
   localparam logic             CORN_ON  = (CORN != 0);

   logic [COORD_W:0] qx_e, qy_e, x0_e, x1_e, y0_e, y1_e;
   logic in_box, left, right, top, bottom, corner;

   always_comb begin
      qx_e   = {1'b0, q_x};
      qy_e   = {1'b0, q_y};
      x0_e   = {1'b0, x0};
      x1_e   = {1'b0, x1};
      y0_e   = {1'b0, y0};
      y1_e   = {1'b0, y1};
      in_box = (qx_e > x0_e) && (qx_e < x1_e) && (qy_e > y0_e) && (qy_e < y1_e);
      left   = qx_e < (x0_e + CORN_E);
      right  = (qx_e + CORN_E) > x1_e;
      top    = qy_e < (y0_e + CORN_E);
      bottom = (qy_e + CORN_E) > y1_e;
      corner = (left | right) & (top | bottom) & cut & CORN_ON;
      match  = en & in_box & ~corner;
   end

endmodule

// File: rtl/rect_region_engine.sv
// Multi-rectangle pixel hit-test engine: double-buffered rectangle table
// committed on frame_start, two-stage registered hit/hit_id pipeline.
module rect_region_engine
   import vga_pkg::*;
#(
   parameter int N_RECT  = 4,
   parameter int COORD_W = DEF_COORD_W,
   parameter int CORN    = 10,
   parameter int ID_W    = (N_RECT > 1) ? $clog2(N_RECT) : 1
) (
   input  logic                 clk,
   input  logic                 rst,
   rect_region_engine_if.slave  cfg,
   input  logic                 frame_start,
   input  logic                 pix_valid,
   input  logic [COORD_W-1:0]   Q_X,
   input  logic [COORD_W-1:0]   Q_Y,
   output logic                 hit_valid,
   output logic                 hit,
   output logic [ID_W-1:0]      hit_id
);

   // Same layout as rect_t but sized by this instance's COORD_W.
   typedef struct packed {
      logic               en;
      logic               cut;
      logic [COORD_W-1:0] x0;
      logic [COORD_W-1:0] x1;
      logic [COORD_W-1:0] y0;
      logic [COORD_W-1:0] y1;
   } entry_t;

   entry_t              shadow [N_RECT];
   entry_t              active [N_RECT];
   logic [N_RECT-1:0]   match;
   logic [N_RECT-1:0]   match_q;
   logic                pv_q;

   // Blocking writes during a commit keeps shadow stable while it is copied.
   assign cfg.cfg_ready = !rst && !frame_start;

   for (genvar i = 0; i < N_RECT; i++) begin : g_cell
      rect_hit_cell #(
         .COORD_W (COORD_W),
         .CORN    (CORN)
      ) u_cell (
         .en    (active[i].en),
         .cut   (active[i].cut),
         .x0    (active[i].x0),
         .x1    (active[i].x1),
         .y0    (active[i].y0),
         .y1    (active[i].y1),
         .q_x   (Q_X),
         .q_y   (Q_Y),
         .match (match[i])
      );
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < N_RECT; i++) begin
            shadow[i] <= '0;
            active[i] <= '0;
         end
         match_q   <= '0;
         pv_q      <= 1'b0;
         hit_valid <= 1'b0;
         hit       <= 1'b0;
         hit_id    <= '0;
      end else begin
         if (cfg.cfg_valid && cfg.cfg_ready && (int'(cfg.cfg_idx) < N_RECT)) begin
            shadow[cfg.cfg_idx] <= '{en:  cfg.cfg_en,  cut: cfg.cfg_cut,
                                     x0:  cfg.cfg_x0,  x1:  cfg.cfg_x1,
                                     y0:  cfg.cfg_y0,  y1:  cfg.cfg_y1};
         end
         if (frame_start) begin
            active <= shadow;
         end
         match_q   <= pix_valid ? match : '0;
         pv_q      <= pix_valid;
         hit_valid <= pv_q;
         hit       <= |match_q;
         hit_id    <= ID_W'(lowest_set_idx(MAX_RECT'(match_q)));
      end
   end

endmodule

// File: tb/tb_rect_region_engine.sv
// Directed, table-driven bench for rect_region_engine (N_RECT=4, COORD_W=10, CORN=10).
module tb_rect_region_engine;

   logic       clk = 1'b0;
   logic       rst;
   logic       frame_start;
   logic       pix_valid;
   logic [9:0] Q_X, Q_Y;
   logic       hit_valid, hit;
   logic [1:0] hit_id;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   rect_region_engine_if #(.ID_W(2), .COORD_W(10)) cfg_bus ();

   rect_region_engine #(
      .N_RECT  (4),
      .COORD_W (10),
      .CORN    (10)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .cfg         (cfg_bus),
      .frame_start (frame_start),
      .pix_valid   (pix_valid),
      .Q_X         (Q_X),
      .Q_Y         (Q_Y),
      .hit_valid   (hit_valid),
      .hit         (hit),
      .hit_id      (hit_id)
   );

   typedef struct {
      logic [9:0] x;
      logic [9:0] y;
      logic       exp_hit;
      logic [1:0] exp_id;
      string      name;
   } vec_t;

   vec_t tbl [8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic write_rect(input logic [1:0] idx, input logic [9:0] x0, input logic [9:0] x1,
                             input logic [9:0] y0, input logic [9:0] y1,
                             input logic en, input logic cut);
      @(negedge clk);
      cfg_bus.cfg_valid = 1'b1;
      cfg_bus.cfg_idx   = idx;
      cfg_bus.cfg_x0    = x0;
      cfg_bus.cfg_x1    = x1;
      cfg_bus.cfg_y0    = y0;
      cfg_bus.cfg_y1    = y1;
      cfg_bus.cfg_en    = en;
      cfg_bus.cfg_cut   = cut;
      @(negedge clk);
      cfg_bus.cfg_valid = 1'b0;
   endtask

   task automatic commit();
      @(negedge clk);
      frame_start = 1'b1;
      @(negedge clk);
      frame_start = 1'b0;
   endtask

   task automatic probe(input logic [9:0] x, input logic [9:0] y,
                        input logic exp_hit, input logic [1:0] exp_id, input string name);
      @(negedge clk);
      pix_valid = 1'b1;
      Q_X = x;
      Q_Y = y;
      @(negedge clk);
      pix_valid = 1'b0;
      @(negedge clk);
      check({name, ".hit_valid"}, 32'(hit_valid), 32'd1);
      check({name, ".hit"},       32'(hit),       32'(exp_hit));
      check({name, ".hit_id"},    32'(hit_id),    32'(exp_id));
   endtask

   initial begin
      logic pvh [12];

      tbl[0] = '{x: 150, y: 150, exp_hit: 1, exp_id: 0, name: "centre"};
      tbl[1] = '{x: 105, y: 105, exp_hit: 0, exp_id: 0, name: "cut_tl"};
      tbl[2] = '{x: 195, y: 195, exp_hit: 0, exp_id: 0, name: "cut_br"};
      tbl[3] = '{x: 100, y: 150, exp_hit: 0, exp_id: 0, name: "edge_x0"};
      tbl[4] = '{x: 199, y: 150, exp_hit: 1, exp_id: 0, name: "right_mid"};
      tbl[5] = '{x: 110, y: 105, exp_hit: 1, exp_id: 0, name: "cut_edge_out"};
      tbl[6] = '{x: 109, y: 109, exp_hit: 0, exp_id: 0, name: "cut_edge_in"};
      tbl[7] = '{x: 150, y: 200, exp_hit: 0, exp_id: 0, name: "edge_y1"};

      rst = 1'b1;
      frame_start = 1'b0;
      pix_valid = 1'b0;
      Q_X = '0;
      Q_Y = '0;
      cfg_bus.cfg_valid = 1'b0;
      cfg_bus.cfg_idx = '0;
      cfg_bus.cfg_x0 = '0;
      cfg_bus.cfg_x1 = '0;
      cfg_bus.cfg_y0 = '0;
      cfg_bus.cfg_y1 = '0;
      cfg_bus.cfg_en = 1'b0;
      cfg_bus.cfg_cut = 1'b0;

      repeat (3) @(negedge clk);
      #1 check("rst.cfg_ready", 32'(cfg_bus.cfg_ready), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("rst.cfg_ready_after", 32'(cfg_bus.cfg_ready), 32'd1);
      check("rst.hit",       32'(hit),       32'd0);
      check("rst.hit_valid", 32'(hit_valid), 32'd0);
      check("rst.hit_id",    32'(hit_id),    32'd0);

      commit();
      probe(150, 150, 0, 0, "empty_table");

      write_rect(0, 100, 200, 100, 200, 1, 1);
      commit();
      for (int i = 0; i < 8; i++) begin
         probe(tbl[i].x, tbl[i].y, tbl[i].exp_hit, tbl[i].exp_id, tbl[i].name);
      end

      write_rect(0, 100, 200, 100, 200, 1, 0);
      commit();
      probe(105, 105, 1, 0, "nocut_tl");

      write_rect(0, 100, 200, 100, 200, 0, 0);
      write_rect(1, 50, 300, 50, 300, 1, 0);
      write_rect(2, 140, 160, 140, 160, 1, 0);
      commit();
      probe(150, 150, 1, 1, "overlap_lowest");
      write_rect(1, 50, 300, 50, 300, 0, 0);
      commit();
      probe(150, 150, 1, 2, "overlap_rect1_off");
      probe(60, 60, 0, 0, "rect1_off_miss");

      write_rect(2, 140, 160, 140, 160, 0, 0);
      write_rect(0, 100, 200, 100, 200, 1, 0);
      commit();
      probe(150, 150, 1, 0, "dbuf_base");
      write_rect(0, 100, 120, 100, 200, 1, 0);
      probe(150, 150, 1, 0, "dbuf_no_commit");
      commit();
      probe(150, 150, 0, 0, "dbuf_committed");

      // write offered during frame_start must stall one cycle
      @(negedge clk);
      frame_start = 1'b1;
      cfg_bus.cfg_valid = 1'b1;
      cfg_bus.cfg_idx = 2'd0;
      cfg_bus.cfg_x0 = 10'd100;
      cfg_bus.cfg_x1 = 10'd200;
      cfg_bus.cfg_y0 = 10'd100;
      cfg_bus.cfg_y1 = 10'd200;
      cfg_bus.cfg_en = 1'b1;
      cfg_bus.cfg_cut = 1'b0;
      #1 check("stall.cfg_ready", 32'(cfg_bus.cfg_ready), 32'd0);
      @(negedge clk);
      frame_start = 1'b0;
      #1 check("stall.cfg_ready_next", 32'(cfg_bus.cfg_ready), 32'd1);
      @(negedge clk);
      cfg_bus.cfg_valid = 1'b0;
      probe(150, 150, 0, 0, "stall_not_yet");
      commit();
      probe(150, 150, 1, 0, "stall_landed");

      write_rect(3, 0, 5, 0, 5, 1, 1);
      write_rect(2, 1020, 1023, 100, 200, 1, 1);
      commit();
      probe(2, 2, 0, 0, "tiny_cut_a");
      probe(4, 4, 0, 0, "tiny_cut_b");
      probe(1021, 105, 0, 0, "far_right_corner");
      probe(1021, 150, 1, 2, "far_right_mid");
      write_rect(3, 0, 5, 0, 5, 1, 0);
      commit();
      probe(2, 2, 1, 3, "tiny_nocut");

      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (i >= 2) begin
            check($sformatf("toggle%0d.hit_valid", i), 32'(hit_valid), 32'(pvh[i-2]));
            check($sformatf("toggle%0d.hit", i),       32'(hit),       32'(pvh[i-2]));
         end
         pvh[i] = (i % 2 == 0);
         pix_valid = pvh[i];
         Q_X = 10'd150;
         Q_Y = 10'd150;
      end
      @(negedge clk);
      pix_valid = 1'b0;
      repeat (2) @(negedge clk);

      @(negedge clk);
      pix_valid = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("inflight.hit", 32'(hit), 32'd1);
      rst = 1'b1;
      #1 check("inflight.cfg_ready", 32'(cfg_bus.cfg_ready), 32'd0);
      @(negedge clk);
      check("inflight_rst.hit",       32'(hit),       32'd0);
      check("inflight_rst.hit_valid", 32'(hit_valid), 32'd0);
      rst = 1'b0;
      pix_valid = 1'b0;
      repeat (2) @(negedge clk);
      check("post_rst.hit",       32'(hit),       32'd0);
      check("post_rst.hit_valid", 32'(hit_valid), 32'd0);
      commit();
      probe(150, 150, 0, 0, "post_rst_r0");
      probe(2, 2, 0, 0, "post_rst_r3");
      probe(1021, 150, 0, 0, "post_rst_r2");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/rect_region_engine.md
Name: rect_region_engine

Overview:
- Multi-rectangle pixel hit-test engine for the VGA pipeline. It is the parametrised successor to the single fixed square-area detector.
- Holds N_RECT runtime-configurable rectangles, each with optional corner cut-outs of CORN pixels.
- Configuration is double-buffered and commits only at frame start, so shapes never tear mid-frame.
- Sits between the VGA timing counter (Q_X/Q_Y) and the colour mux. It returns a registered hit flag and the winning rectangle index.

Parameters:
- N_RECT, 4, number of rectangles (1..16)
- COORD_W, 10, pixel coordinate width
- CORN, 10, corner cut-out size in pixels (0 disables cut-outs globally)
- ID_W, $clog2(N_RECT) (min 1), width of index fields

Ports:
- clk  in  1  pixel clock
- rst  in  1  synchronous active-high reset
- cfg_valid  in  1  config write request
- cfg_ready  out  1  config write accepted when valid&ready
- cfg_idx  in  ID_W  target rectangle
- cfg_x0, cfg_x1, cfg_y0, cfg_y1  in  COORD_W each  bounds (exclusive)
- cfg_en  in  1  rectangle enable
- cfg_cut  in  1  apply corner cut-outs to this rectangle
- frame_start  in  1  one-cycle pulse at start of vertical blank
- pix_valid  in  1  Q_X/Q_Y are an active-area pixel
- Q_X, Q_Y  in  COORD_W  current pixel coordinate
- hit_valid  out  1  pix_valid delayed 2 cycles
- hit  out  1  pixel lies inside at least one enabled rectangle
- hit_id  out  ID_W  lowest index of the matching rectangles

Behaviour:
- Reset:
  - All shadow and active entries cleared: en=0, cut=0, bounds=0.
  - hit_valid=0, hit=0, hit_id=0.
  - cfg_ready=1 from the first cycle after rst deasserts; cfg_ready=0 while rst=1.
- Config write:
  - On cfg_valid&cfg_ready, shadow[cfg_idx] is loaded with all cfg_* fields in that cycle.
  - cfg_idx >= N_RECT is accepted and discarded.
- Commit:
  - On frame_start=1, active[i] <= shadow[i] for all i in one cycle.
  - cfg_ready = !rst && !frame_start, so a write and a commit never coincide. A write stalled by frame_start lands on the next cycle and takes effect at the following frame.
- Hit test, per active rectangle i:
  - in_box = Q_X>x0 && Q_X<x1 && Q_Y>y0 && Q_Y<y1 (strict inequalities).
  - Corner zones use strict inequalities: left = Q_X<x0+CORN; right = Q_X+CORN>x1; top = Q_Y<y0+CORN; bottom = Q_Y+CORN>y1.
  - All additions are computed at COORD_W+1 bits, so no underflow or wrap occurs.
  - corner = (left|right)&(top|bottom)&cut&(CORN!=0).
  - match[i] = en & in_box & !corner.
- Degenerate rectangles (x1<=x0+1 or y1<=y0+1) never match.
- If a rectangle is narrower than 2*CORN, its corner zones may overlap; the pixel is simply excluded, with no error.
- Pipeline:
  - Stage 1 registers match[N_RECT-1:0] and pix_valid.
  - Stage 2 registers hit=|match, hit_id=lowest set index (0 if none), and hit_valid.
  - Latency is exactly 2 cycles. Throughput is 1 pixel per cycle, with no stalls.
- When pix_valid=0:
  - The stage-1 match vector is forced to 0.
  - hit=0 and hit_id=0 two cycles later.
- Commit mid-pipeline: pixels already in stage 1 or stage 2 keep results computed with the old active set. Only pixels sampled after the commit cycle use the new set.
- Reset mid-operation: pipeline registers clear on the same edge, and no stale hit emerges after rst falls.

Decomposition:
- Shared package vga_pkg:
  - typedef rect_t {logic en; logic cut; logic [COORD_W-1:0] x0,x1,y0,y1;}
  - COORD_W default constant
  - function lowest_set_idx
- One sub-module, rect_hit_cell:
  - Purely combinational per-rectangle test (in_box, corner, match), instantiated N_RECT times via generate.

Test Plan:
- Reset then rect0 = (100,200,100,200), en=1, cut=1, frame_start, then scan:
  - (150,150) -> hit=1, hit_id=0 after 2 cycles
  - (105,105) and (195,195) -> hit=0 (corner cut)
  - (100,150) -> hit=0 (boundary is exclusive)
- Same rectangle with cut=0: (105,105) -> hit=1.
- Overlapping rectangles: rect1 = (50,300,50,300), rect2 = (140,160,140,160), both en=1:
  - (150,150) -> hit_id=1
  - Disable rect1, commit, then (150,150) -> hit_id=2
- Double-buffering: write rect0 x1=120 mid-frame with no frame_start.
  - (150,150) still hits until the next frame_start, then misses.
  - Assert cfg_valid while frame_start=1 -> cfg_ready=0; the write is accepted on the next cycle.
- Edge cases:
  - rect with x0=0, x1=5, CORN=10: no wrap, and no pixel matches with cut=1.
  - rect (1020,1023,...) at COORD_W=10: Q_X+CORN is computed without overflow.
- Pipeline and reset: pix_valid toggles every cycle -> hit_valid mirrors it with a 2-cycle delay. Assert rst with hit=1 in flight -> hit=0, hit_valid=0 the next cycle, and all rectangles are disabled.
